// File: rtl/serial_word_comp_pkg.sv
// Shared constants, FSM state type and helpers for the serial word comparator.
package serial_word_comp_pkg;

  localparam int NIB_W = 4;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble index width; a single-nibble word still needs a 1-bit index.
  function automatic int idx_width(input int nibs);
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage

// File: rtl/serial_word_comp_if.sv
// Operand/result handshake bundle for serial_word_comp.
// A transfer happens on a rising clk edge where valid and ready are both 1;
// the source holds valid and its payload stable until that edge, and ready
// never depends combinationally on valid.
interface serial_word_comp_if #(
  parameter int WORD_W = 16
) ();
  localparam int NIBS  = WORD_W / serial_word_comp_pkg::NIB_W;
  localparam int IDX_W = serial_word_comp_pkg::idx_width(NIBS);

  logic                                  in_valid;
  logic                                  in_ready;
  logic [WORD_W-1:0]                     a;
  logic [WORD_W-1:0]                     b;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  equal;
  logic [IDX_W-1:0]                      mismatch_idx;
  logic [serial_word_comp_pkg::CNT_W-1:0] match_cnt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, equal, mismatch_idx, match_cnt
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, equal, mismatch_idx, match_cnt
  );
endinterface

// File: rtl/serial_word_comp_nib_eq.sv
// Combinational 4-bit equality used by the serial comparator, one nibble per cycle.
module nib_eq
  import serial_word_comp_pkg::*;
(
  input  logic [NIB_W-1:0] a_nib,
  input  logic [NIB_W-1:0] b_nib,
  output logic             eq
);
  assign eq = (a_nib == b_nib);
endmodule

// File: rtl/serial_word_comp.sv
// Nibble-serial equality comparator, LSB nibble first, valid/ready in and out.
// Build option: define SERIAL_WORD_COMP_EARLY_EXIT_EN to stop scanning at the first mismatch.
module serial_word_comp
  import serial_word_comp_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_word_comp_if.slave   bus,
  output state_t              dbg_state
);
  localparam int NIBS  = WORD_W / NIB_W;
  localparam int IDX_W = idx_width(NIBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  state_t                       state, state_nxt;
  logic [WORD_W-1:0]            a_q, b_q;
  logic [NIBS-1:0][NIB_W-1:0]   a_nibs, b_nibs;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             mis_idx_q;
  logic [IDX_W-1:0]             mismatch_idx_q;
  logic [IDX_W-1:0]             first_mis;
  logic                         mis_found_q;
  logic                         eq_acc_q;
  logic                         equal_q;
  logic [CNT_W-1:0]             match_cnt_q;
  logic                         nib_equal;
  logic                         eq_final;
  logic                         cmp_done;
  logic                         accept;
  logic                         handoff;
  logic                         in_ready_c;
  logic                         out_valid_c;

  assign a_nibs = a_q;
  assign b_nibs = b_q;

  nib_eq u_nib_eq (
    .a_nib (a_nibs[idx_q]),
    .b_nib (b_nibs[idx_q]),
    .eq    (nib_equal)
  );

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    handoff     = 1'b0;
    eq_final    = eq_acc_q & nib_equal;
    first_mis   = mis_found_q ? mis_idx_q : idx_q;
`ifdef SERIAL_WORD_COMP_EARLY_EXIT_EN
    cmp_done    = (idx_q == LAST_IDX) || !nib_equal;
`else
    cmp_done    = (idx_q == LAST_IDX);
`endif
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (cmp_done) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        // in_valid is deliberately not looked at here; acceptance waits for IDLE.
        if (bus.out_ready) begin
          handoff   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q            <= '0;
      b_q            <= '0;
      idx_q          <= '0;
      eq_acc_q       <= 1'b0;
      mis_found_q    <= 1'b0;
      mis_idx_q      <= '0;
      equal_q        <= 1'b0;
      mismatch_idx_q <= '0;
      match_cnt_q    <= '0;
    end else begin
      if (accept) begin
        a_q         <= bus.a;
        b_q         <= bus.b;
        idx_q       <= '0;
        eq_acc_q    <= 1'b1;
        mis_found_q <= 1'b0;
        mis_idx_q   <= '0;
      end else if (state == CMP) begin
        eq_acc_q <= eq_final;
        if (!nib_equal && !mis_found_q) begin
          mis_found_q <= 1'b1;
          mis_idx_q   <= idx_q;
        end
        if (cmp_done) begin
          equal_q        <= eq_final;
          // An equal result reports index 0, same as a nibble-0 miss; equal disambiguates.
          mismatch_idx_q <= eq_final ? '0 : first_mis;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (handoff && equal_q && (match_cnt_q != CNT_MAX))
        match_cnt_q <= match_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.equal        = equal_q;
  assign bus.mismatch_idx = mismatch_idx_q;
  assign bus.match_cnt    = match_cnt_q;
  assign dbg_state        = state;

endmodule
